// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction_arena game: FSM state encodings and
// the LFSR seed/tap constants plus the LFSR step function.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_ARMED = 3'b001,
        ST_LIT   = 3'b010,
        ST_LATE  = 3'b011,
        ST_VALID = 3'b100,
        ST_EARLY = 3'b110
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hDEAD;
    // Taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fibonacci step: XOR of the tapped bits enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {r[14:0], ^(r & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/press_detect.sv
// Per-button debounce and press edge detection. A press pulse is emitted
// one registered cycle after a low sample, but only when the button had been
// released long enough for the release-stability counter to saturate.
module press_detect #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_pulse
);

    logic [DEBOUNCE_W-1:0] rel_q, rel_d;
    logic                  pulse_q, pulse_d;

    // Pressed clears the stability counter; released counts up to saturation.
    always_comb begin
        pulse_d = 1'b0;
        rel_d   = rel_q;
        if (!i_btn_n) begin
            pulse_d = &rel_q;
            rel_d   = '0;
        end else if (!(&rel_q)) begin
            rel_d = rel_q + DEBOUNCE_W'(1);
        end
    end

    // Counter starts saturated so the first press after reset is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rel_q   <= '1;
            pulse_q <= 1'b0;
        end else begin
            rel_q   <= rel_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/reaction_arena.sv
// Multi-player reaction-time game. Any press arms a random delay; pressing
// before the light is a foul (EARLY), pressing after it records a reaction
// time (VALID), waiting too long gives LATE. Results are shown for
// HOLD_CYCLES before returning to IDLE.
// Optional best-time tracking is compiled in with REACTION_BEST_EN.
module reaction_arena
    import reaction_pkg::*;
#(
    parameter int PLAYERS      = 4,
    parameter int TICK_W       = 28,
    parameter int MIN_DELAY    = 25_000_000,
    parameter int DELAY_SHIFT  = 10,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int COMPENSATION = 0,
    parameter int DEBOUNCE_W   = 16
) (
    input  logic                i_clk_50m,
    input  logic                i_rst,
    input  logic [PLAYERS-1:0]  i_btn_n,
    output logic [2:0]          o_state,
    output logic [TICK_W-1:0]   o_ticks,
    output logic [2:0]          o_winner,
    output logic                o_tie,
    output logic [PLAYERS-1:0]  o_early_mask,
    output logic [TICK_W-1:0]   o_best_ticks,
    output logic                o_best_valid,
    output logic [15:0]         o_dbg_rnd
);

    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [PLAYERS-1:0] press;
    logic               any_press;
    logic               press_multi;
    logic [2:0]         press_idx;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  cnt_q, cnt_d;
    logic [TICK_W-1:0]  target_q, target_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TICK_W-1:0]  ticks_q, ticks_d;
    logic [2:0]         winner_q, winner_d;
    logic               tie_q, tie_d;
    logic [PLAYERS-1:0] mask_q, mask_d;
    logic [15:0]        lfsr_q;

    logic [TICK_W-1:0]  target_new;
    logic [TICK_W-1:0]  ticks_new;

    genvar g;
    generate
        for (g = 0; g < PLAYERS; g++) begin : g_btn
            press_detect #(.DEBOUNCE_W(DEBOUNCE_W)) u_press (
                .i_clk   (i_clk_50m),
                .i_rst   (i_rst),
                .i_btn_n (i_btn_n[g]),
                .o_pulse (press[g])
            );
        end
    endgenerate

    function automatic logic [2:0] lowest_idx(input logic [PLAYERS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int k = PLAYERS - 1; k >= 0; k--) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

    assign any_press   = |press;
    assign press_multi = |(press & (press - PLAYERS'(1)));
    assign press_idx   = lowest_idx(press);

    // Delay and compensation are computed wide, then truncated to the tick width.
    assign target_new = TICK_W'(64'(MIN_DELAY) + (64'(lfsr_q) << DELAY_SHIFT));
    assign ticks_new  = (64'(cnt_q) >= 64'(COMPENSATION))
                      ? TICK_W'(64'(cnt_q) - 64'(COMPENSATION)) : '0;

    // Game sequencing; a press always wins over timer events in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        hold_d   = hold_q;
        ticks_d  = ticks_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        mask_d   = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (any_press) begin
                    cnt_d    = '0;
                    target_d = target_new;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (any_press) begin
                    state_d  = ST_EARLY;
                    mask_d   = press;
                    winner_d = press_idx;
                    tie_d    = press_multi;
                    hold_d   = '0;
                end else if (cnt_q >= target_q) begin
                    cnt_d   = '0;
                    state_d = ST_LIT;
                end else begin
                    cnt_d = cnt_q + TICK_W'(1);
                end
            end
            ST_LIT: begin
                if (any_press) begin
                    state_d  = ST_VALID;
                    winner_d = press_idx;
                    tie_d    = press_multi;
                    ticks_d  = ticks_new;
                    mask_d   = '0;
                    hold_d   = '0;
                end else if (&cnt_q) begin
                    state_d = ST_LATE;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + TICK_W'(1);
                end
            end
            ST_LATE, ST_EARLY, ST_VALID: begin
                if (hold_q == HOLD_LAST) state_d = ST_IDLE;
                else                     hold_d  = hold_q + HOLD_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Game state and result registers.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            hold_q   <= '0;
            ticks_q  <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            ticks_q  <= ticks_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            mask_q   <= mask_d;
        end
    end

    // Free-running random source, advancing every cycle.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

`ifdef REACTION_BEST_EN
    logic [TICK_W-1:0] best_q;
    logic              best_vld_q;
    logic              best_hit;

    assign best_hit = (state_q == ST_LIT) && any_press;

    // Keep the fastest valid reaction seen since reset.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            best_q     <= '1;
            best_vld_q <= 1'b0;
        end else if (best_hit && (!best_vld_q || ticks_new < best_q)) begin
            best_q     <= ticks_new;
            best_vld_q <= 1'b1;
        end
    end

    assign o_best_ticks = best_q;
    assign o_best_valid = best_vld_q;
`else
    assign o_best_ticks = '1;
    assign o_best_valid = 1'b0;
`endif

    assign o_state      = state_q;
    assign o_ticks      = ticks_q;
    assign o_winner     = winner_q;
    assign o_tie        = tie_q;
    assign o_early_mask = mask_q;
    assign o_dbg_rnd    = lfsr_q;

endmodule

// File: tb/tb_reaction_arena.sv
// Self-checking bench for reaction_arena: directed game scenarios with literal
// expectations plus a randomized button phase, all compared every cycle
// against a timestamp-based behavioural model.
module tb_reaction_arena;

    localparam int P = 4;
    localparam int TW = 8;
`ifdef REACTION_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_ARMED = 1, S_LIT = 2, S_LATE = 3, S_VALID = 4, S_EARLY = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [P-1:0]  btn_n = '1;
    logic [2:0]    o_state;
    logic [TW-1:0] o_ticks;
    logic [2:0]    o_winner;
    logic          o_tie;
    logic [P-1:0]  o_early_mask;
    logic [TW-1:0] o_best_ticks;
    logic          o_best_valid;
    logic [15:0]   o_dbg_rnd;

    always #5 clk = ~clk;

    reaction_arena #(
        .PLAYERS(P), .TICK_W(TW), .MIN_DELAY(20), .DELAY_SHIFT(0),
        .HOLD_CYCLES(10), .COMPENSATION(3), .DEBOUNCE_W(4)
    ) dut (
        .i_clk_50m    (clk),
        .i_rst        (rst),
        .i_btn_n      (btn_n),
        .o_state      (o_state),
        .o_ticks      (o_ticks),
        .o_winner     (o_winner),
        .o_tie        (o_tie),
        .o_early_mask (o_early_mask),
        .o_best_ticks (o_best_ticks),
        .o_best_valid (o_best_valid),
        .o_dbg_rnd    (o_dbg_rnd)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ---------------- behavioural model ----------------
    int          m_state;
    logic [15:0] m_lfsr;
    logic [P-1:0] m_pulse;
    int          m_last_low[P];
    bit          m_ever_low[P];
    int          m_start, m_target, m_ticks, m_winner, m_best;
    bit          m_tie, m_best_valid, m_live = 1'b0;
    logic [P-1:0] m_mask;

    function automatic logic [15:0] lfsr_step(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    function automatic int lowest(input logic [P-1:0] v);
        for (int k = 0; k < P; k++) if (v[k]) return k;
        return 0;
    endfunction

    function automatic int popc(input logic [P-1:0] v);
        int c = 0;
        for (int k = 0; k < P; k++) c += int'(v[k]);
        return c;
    endfunction

    // Stage-start timestamps give elapsed counts; a player's press counts only if
    // it had 15+ released samples since its previous low (or none since reset).
    always @(posedge clk) begin : model
        logic [P-1:0] p, np;
        logic [15:0]  r;
        int           el;
        p = m_pulse;
        r = m_lfsr;
        if (rst) begin
            m_state = S_IDLE; m_lfsr = 16'hDEAD; m_pulse = '0; m_target = 0;
            m_ticks = 0; m_winner = 0; m_tie = 0; m_mask = '0;
            m_best = 255; m_best_valid = 0; m_start = 0; m_live = 1'b1;
            for (int k = 0; k < P; k++) m_ever_low[k] = 0;
        end else begin
            el = cyc - m_start;
            case (m_state)
                S_IDLE: if (p != 0) begin
                    m_state = S_ARMED; m_start = cyc + 1;
                    m_target = (20 + int'(r)) % 256;
                end
                S_ARMED: if (p != 0) begin
                    m_state = S_EARLY; m_mask = p; m_winner = lowest(p);
                    m_tie = popc(p) > 1; m_start = cyc + 1;
                end else if (el >= m_target) begin
                    m_state = S_LIT; m_start = cyc + 1;
                end
                S_LIT: if (p != 0) begin
                    m_state = S_VALID; m_ticks = (el > 3) ? el - 3 : 0;
                    m_winner = lowest(p); m_tie = popc(p) > 1; m_mask = '0;
                    if (BEST_EN && (!m_best_valid || m_ticks < m_best)) begin
                        m_best = m_ticks; m_best_valid = 1;
                    end
                    m_start = cyc + 1;
                end else if (el == 255) begin
                    m_state = S_LATE; m_start = cyc + 1;
                end
                default: if (el == 9) m_state = S_IDLE;
            endcase
            for (int k = 0; k < P; k++) begin
                np[k] = 1'b0;
                if (!btn_n[k]) begin
                    np[k] = !m_ever_low[k] || (cyc - m_last_low[k] > 15);
                    m_last_low[k] = cyc;
                    m_ever_low[k] = 1;
                end
            end
            m_pulse = np;
            m_lfsr  = lfsr_step(r);
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("state",  32'(o_state), 32'(m_state));
            chk("rnd",    32'(o_dbg_rnd), 32'(m_lfsr));
            chk("ticks",  32'(o_ticks), 32'(m_ticks));
            chk("winner", 32'(o_winner), 32'(m_winner));
            chk("tie",    32'(o_tie), 32'(m_tie));
            chk("mask",   32'(o_early_mask), 32'(m_mask));
            chk("best",   32'(o_best_ticks), 32'(m_best));
            chk("best_v", 32'(o_best_valid), 32'(m_best_valid));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int i = 0;
        while (int'(o_state) != s && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 32'(o_state), 32'(s));
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_state"}, 32'(o_state), 0);
        chk({nm, "_ticks"}, 32'(o_ticks), 0);
        chk({nm, "_winner"}, 32'(o_winner), 0);
        chk({nm, "_tie"}, 32'(o_tie), 0);
        chk({nm, "_mask"}, 32'(o_early_mask), 0);
        chk({nm, "_best"}, 32'(o_best_ticks), 32'hFF);
        chk({nm, "_bestv"}, 32'(o_best_valid), 0);
        chk({nm, "_rnd"}, 32'(o_dbg_rnd), 32'hDEAD);
    endtask

    // Player 2 starts a round; returns on the first LIT cycle.
    task automatic arm_and_light();
        int tgt, n;
        btn_n[2] = 1'b0;
        @(negedge clk);
        tgt = (20 + int'(m_lfsr[7:0])) % 256;
        @(negedge clk);
        chk("armed_entry", 32'(o_state), S_ARMED);
        btn_n[2] = 1'b1;
        n = 0;
        while (int'(o_state) == S_ARMED && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("armed_len", 32'(n), 32'(tgt + 1));
        chk("lit_entry", 32'(o_state), S_LIT);
    endtask

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;
        @(negedge clk);
        chk("lfsr_first_step", 32'(o_dbg_rnd), 32'hBD5B);

        // Valid reaction five cycles into LIT.
        idle(20);
        arm_and_light();
        idle(4);
        btn_n[1] = 1'b0;
        wait_state(S_VALID, 10, "valid_entry");
        btn_n[1] = 1'b1;
        chk("v_ticks", 32'(o_ticks), 2);
        chk("v_winner", 32'(o_winner), 1);
        chk("v_tie", 32'(o_tie), 0);
        chk("v_best", 32'(o_best_ticks), BEST_EN ? 2 : 32'hFF);
        chk("v_bestv", 32'(o_best_valid), 32'(BEST_EN));
        idle(9);
        chk("hold_last", 32'(o_state), S_VALID);
        idle(1);
        chk("hold_done", 32'(o_state), S_IDLE);

        // Simultaneous early presses.
        idle(20);
        btn_n[2] = 1'b0;
        idle(2);
        chk("armed_entry2", 32'(o_state), S_ARMED);
        btn_n[2] = 1'b1;
        btn_n[0] = 1'b0;
        btn_n[3] = 1'b0;
        idle(2);
        if (m_target >= 1) begin
            chk("e_state", 32'(o_state), S_EARLY);
            chk("e_mask", 32'(o_early_mask), 32'b1001);
            chk("e_winner", 32'(o_winner), 0);
            chk("e_tie", 32'(o_tie), 1);
            chk("e_ticks_held", 32'(o_ticks), 2);
        end
        btn_n[0] = 1'b1;
        btn_n[3] = 1'b1;
        wait_state(S_IDLE, 400, "e_idle");

        // Timeout to LATE, presses ignored in hold, then a slower valid time.
        idle(20);
        arm_and_light();
        n = 0;
        while (int'(o_state) == S_LIT && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("lit_len", 32'(n), 256);
        chk("late_state", 32'(o_state), S_LATE);
        btn_n[1] = 1'b0;
        idle(3);
        chk("late_ignore", 32'(o_state), S_LATE);
        chk("late_ticks", 32'(o_ticks), 2);
        btn_n[1] = 1'b1;
        wait_state(S_IDLE, 20, "late_idle");
        idle(20);
        arm_and_light();
        idle(9);
        btn_n[1] = 1'b0;
        wait_state(S_VALID, 10, "valid7_entry");
        btn_n[1] = 1'b1;
        chk("v7_ticks", 32'(o_ticks), 7);
        chk("v7_best", 32'(o_best_ticks), BEST_EN ? 2 : 32'hFF);
        wait_state(S_IDLE, 20, "v7_idle");

        // Press on the cycle after the light: compensation saturates.
        idle(20);
        arm_and_light();
        btn_n[1] = 1'b0;
        wait_state(S_VALID, 10, "valid0_entry");
        btn_n[1] = 1'b1;
        chk("v0_ticks", 32'(o_ticks), 0);
        chk("v0_best", 32'(o_best_ticks), BEST_EN ? 0 : 32'hFF);
        wait_state(S_IDLE, 20, "v0_idle");

        // Held press gives one pulse; quick re-press gives none.
        idle(20);
        btn_n[2] = 1'b0;
        idle(40);
        chk("held_single", 32'(o_state == 3'b110 || o_state == 3'b100), 0);
        btn_n[2] = 1'b1;
        idle(5);
        btn_n[2] = 1'b0;
        idle(3);
        btn_n[2] = 1'b1;
        chk("repress_blocked", 32'(o_state == 3'b110 || o_state == 3'b100), 0);
        wait_state(S_LIT, 600, "lit_for_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_lit");
        rst = 1'b0;

        // Randomized play with occasional resets.
        idle(20);
        repeat (4000) begin
            @(negedge clk);
            for (int k = 0; k < P; k++)
                if ($urandom_range(47, 0) == 0) btn_n[k] = ~btn_n[k];
            rst = ($urandom_range(1999, 0) == 0);
        end
        btn_n = '1;
        rst = 1'b0;
        idle(30);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
